recorder_ctrl: RTL and testbench

//  Record/playback sequencer that sits directly upstream of the sram access block.

---
 rtl/recorder_ctrl.sv | 157 +++++++++++++++
 tb/tb_recorder_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/recorder_ctrl.sv
// recorder_ctrl: record/playback sequencer that sits directly upstream of the
// sram access block.
//
// Turns one-cycle user commands and per-sample codec strobes into sram
// addr/read/write controls. It records one sample per address, remembers how
// many samples were stored, and replays them in order, one per codec strobe.
//
// Ports:
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   btn_record/play/stop  one-cycle command pulses (already debounced)
//   sample_valid          one-cycle strobe per codec sample period
//   sample_in             sample to record, qualified by sample_valid
//   addr                  sram word address
//   read, write           sram access requests, each held ACC_CYCLES cycles
//   play, record          high for the whole play / record session
//   data                  sram data bus; driven only while record=1
//   sample_out            played-back sample
//   sample_out_valid      one-cycle strobe, sample_out updated
//   length                number of samples stored (0..2^ADDR_W)
//   overrun               one-cycle pulse: a strobe arrived mid-access and was dropped
//   done                  one-cycle pulse: a session ended
//   dbg_state             current FSM state, for observation only
//
// Handshake: there is no back-pressure. Commands and strobes are one-cycle
// pulses sampled on the rising edge; a strobe that lands during an access is
// dropped (overrun), a stop that lands during an access is held until the
// access completes.
module recorder_ctrl #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int ACC_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              btn_record,
  input  logic              btn_play,
  input  logic              btn_stop,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  output logic [ADDR_W-1:0] addr,
  output logic              read,
  output logic              write,
  output logic              play,
  output logic              record,
  inout  wire  [DATA_W-1:0] data,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_out_valid,
  output logic [ADDR_W:0]   length,
  output logic              overrun,
  output logic              done,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REC_WAIT  = 3'd1,
    REC_ACC   = 3'd2,
    PLAY_WAIT = 3'd3,
    PLAY_ACC  = 3'd4
  } state_t;

  localparam logic [2:0]        ACC_LAST = 3'(ACC_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            state, state_next;
  logic [2:0]        acc_cnt;
  logic              stop_pend;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W:0]   addr_inc;
  logic              in_acc;
  logic              acc_last;
  logic              stop_now;

  assign in_acc   = (state == REC_ACC) || (state == PLAY_ACC);
  assign acc_last = in_acc && (acc_cnt == ACC_LAST);
  // A stop arriving on the last access cycle ends the session just like a held one.
  assign stop_now = stop_pend || btn_stop;
  assign addr_inc = {1'b0, addr} + {{ADDR_W{1'b0}}, 1'b1};

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (btn_record)                 state_next = REC_WAIT;
        else if (btn_play && length != '0) state_next = PLAY_WAIT;
      end
      REC_WAIT: begin
        if (btn_stop)          state_next = IDLE;
        else if (sample_valid) state_next = REC_ACC;
      end
      REC_ACC: begin
        if (acc_last) state_next = (addr == ADDR_MAX || stop_now) ? IDLE : REC_WAIT;
      end
      PLAY_WAIT: begin
        if (btn_stop)          state_next = IDLE;
        else if (sample_valid) state_next = PLAY_ACC;
      end
      PLAY_ACC: begin
        if (acc_last) state_next = (addr_inc == length || stop_now) ? IDLE : PLAY_WAIT;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode: session and access levels follow the state directly,
  // which also makes read and write mutually exclusive by construction.
  always_comb begin
    record    = (state == REC_WAIT)  || (state == REC_ACC);
    play      = (state == PLAY_WAIT) || (state == PLAY_ACC);
    write     = (state == REC_ACC);
    read      = (state == PLAY_ACC);
    dbg_state = state;
  end

  assign data = record ? data_q : {DATA_W{1'bz}};

  // Datapath and pulse outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_cnt          <= '0;
      stop_pend        <= 1'b0;
      data_q           <= '0;
      addr             <= '0;
      length           <= '0;
      sample_out       <= '0;
      sample_out_valid <= 1'b0;
      overrun          <= 1'b0;
      done             <= 1'b0;
    end else begin
      acc_cnt          <= (in_acc && !acc_last) ? acc_cnt + 3'd1 : 3'd0;
      // The held stop is consumed on the last access cycle.
      stop_pend        <= in_acc && !acc_last && stop_now;
      overrun          <= in_acc && sample_valid;
      sample_out_valid <= (state == PLAY_ACC) && acc_last;
      done             <= (state != IDLE) && (state_next == IDLE);

      if (state == REC_WAIT && state_next == REC_ACC) data_q <= sample_in;
      if (state == PLAY_ACC && acc_last)              sample_out <= data;

      // Session start rewinds the address; a new recording forgets the old length.
      if (state == IDLE && state_next != IDLE) addr <= '0;
      if (state == IDLE && state_next == REC_WAIT) length <= '0;

      if (state == REC_ACC && acc_last) length <= addr_inc;
      if (acc_last && (state_next == REC_WAIT || state_next == PLAY_WAIT))
        addr <= addr + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_recorder_ctrl.sv
// Bench for recorder_ctrl with a 16-word memory. The reference model is a
// word array plus a stored length, updated per recorded sample; expected
// playback samples go through a queue checked by a monitor.
module tb_recorder_ctrl;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int ACC    = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  // Clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic              btn_record = 0, btn_play = 0, btn_stop = 0, sample_valid = 0;
  logic [DATA_W-1:0] sample_in = '0;
  logic [ADDR_W-1:0] addr;
  logic              read, write, play, record;
  wire  [DATA_W-1:0] data;
  logic [DATA_W-1:0] sample_out;
  logic              sample_out_valid;
  logic [ADDR_W:0]   length;
  logic              overrun, done;
  logic [2:0]        dbg_state;

  recorder_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_CYCLES(ACC)) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_record(btn_record), .btn_play(btn_play), .btn_stop(btn_stop),
    .sample_valid(sample_valid), .sample_in(sample_in),
    .addr(addr), .read(read), .write(write), .play(play), .record(record),
    .data(data), .sample_out(sample_out), .sample_out_valid(sample_out_valid),
    .length(length), .overrun(overrun), .done(done), .dbg_state(dbg_state)
  );

  // Bench sram: stores write bursts, returns the addressed word while read=1.
  logic [DATA_W-1:0] sram [DEPTH];
  assign data = read ? sram[addr] : {DATA_W{1'bz}};
  always @(posedge clk) if (write) sram[addr] <= data;

  // Reference model and scoreboard
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                ref_len = 0;
  int                exp_wc  = 0;
  int                write_cycles = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_mon;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Monitor: counts write cycles, checks read/write exclusion, scores playback.
  always @(negedge clk) begin
    if (reset_n) begin
      if (write) write_cycles++;
      if (read || write) check("rw_exclusive", 32'(read & write), 0);
      if (sample_out_valid) begin
        if (exp_q.size() == 0) check("sov_unexpected", 1, 0);
        else begin
          exp_mon = exp_q.pop_front();
          check("sample_out", 32'(sample_out), 32'(exp_mon));
        end
      end
    end
  end

  // Driver tasks
  task automatic rec_start();
    btn_record = 1; tick(); btn_record = 0;
    ref_len = 0;
    check("rec_start_record", 32'(record), 1);
    check("rec_start_length", 32'(length), 0);
    check("rec_start_addr",   32'(addr), 0);
  endtask

  task automatic rec_stop();
    btn_stop = 1; tick(); btn_stop = 0;
    check("rec_stop_done",   32'(done), 1);
    check("rec_stop_record", 32'(record), 0);
    check("rec_stop_length", 32'(length), 32'(ref_len));
    tick();
    check("rec_stop_done_pulse", 32'(done), 0);
  endtask

  task automatic rec_sample(input logic [DATA_W-1:0] d, input bit ovr, input bit stp,
                            output bit ended);
    int idx;
    idx = ref_len;
    repeat ($urandom_range(0, 3)) tick();
    sample_valid = 1; sample_in = d; tick();
    sample_valid = 0; sample_in = DATA_W'($urandom);
    for (int k = 0; k < ACC; k++) begin
      check("rec_write", 32'(write), 1);
      check("rec_addr",  32'(addr), 32'(idx));
      check("rec_data",  32'(data), 32'(d));
      if (k == 0) begin
        sample_valid = ovr; btn_stop = stp;
      end
      tick();
      if (k == 0) begin
        sample_valid = 0; btn_stop = 0;
        check("rec_overrun", 32'(overrun), 32'(ovr));
      end
    end
    ref_mem[idx] = d;
    ref_len = idx + 1;
    exp_wc += ACC;
    ended = (idx == DEPTH - 1) || stp;
    check("rec_write_end", 32'(write), 0);
    check("rec_length",    32'(length), 32'(ref_len));
    check("rec_done",      32'(done), 32'(ended));
    check("rec_record",    32'(record), 32'(!ended));
    if (!ended) check("rec_addr_inc", 32'(addr), 32'(idx + 1));
  endtask

  task automatic play_start();
    bit starts;
    starts = (ref_len != 0);
    btn_play = 1; tick(); btn_play = 0;
    check("play_start_play",  32'(play), 32'(starts));
    check("play_start_read",  32'(read), 0);
    check("play_start_write", 32'(write), 0);
    if (starts) check("play_start_addr", 32'(addr), 0);
  endtask

  task automatic play_stop();
    btn_stop = 1; tick(); btn_stop = 0;
    check("play_stop_done", 32'(done), 1);
    check("play_stop_play", 32'(play), 0);
  endtask

  task automatic play_sample(input int idx, input bit ovr, input bit stp, output bit ended);
    repeat ($urandom_range(0, 3)) tick();
    exp_q.push_back(ref_mem[idx]);
    sample_valid = 1; tick(); sample_valid = 0;
    for (int k = 0; k < ACC; k++) begin
      check("play_read",   32'(read), 1);
      check("play_addr",   32'(addr), 32'(idx));
      check("play_record", 32'(record), 0);
      if (k == 0) begin
        sample_valid = ovr; btn_stop = stp;
      end
      tick();
      if (k == 0) begin
        sample_valid = 0; btn_stop = 0;
        check("play_overrun", 32'(overrun), 32'(ovr));
      end
    end
    ended = (idx + 1 == ref_len) || stp;
    check("play_read_end", 32'(read), 0);
    check("play_sov",      32'(sample_out_valid), 1);
    check("play_done",     32'(done), 32'(ended));
    check("play_play",     32'(play), 32'(!ended));
    check("play_length",   32'(length), 32'(ref_len));
  endtask

  // Main sequence
  initial begin
    bit ended;
    int n, m;

    repeat (3) tick();
    check("rst_addr",   32'(addr), 0);
    check("rst_read",   32'(read), 0);
    check("rst_write",  32'(write), 0);
    check("rst_play",   32'(play), 0);
    check("rst_record", 32'(record), 0);
    check("rst_sout",   32'(sample_out), 0);
    check("rst_sov",    32'(sample_out_valid), 0);
    check("rst_length", 32'(length), 0);
    check("rst_overrun",32'(overrun), 0);
    check("rst_done",   32'(done), 0);
    reset_n = 1;
    tick();

    // Stop in IDLE and play with nothing stored are both ignored.
    btn_stop = 1; tick(); btn_stop = 0;
    check("idle_stop_done", 32'(done), 0);
    play_start();

    // Three fixed samples, stop, then replay all three.
    rec_start();
    btn_play = 1; tick(); btn_play = 0;
    check("rec_ignore_play", 32'(play), 0);
    rec_sample(16'h0011, 0, 0, ended);
    rec_sample(16'h0022, 0, 0, ended);
    rec_sample(16'h0033, 0, 0, ended);
    rec_stop();
    check("wc_three", 32'(write_cycles), 32'(exp_wc));
    play_start();
    btn_record = 1; tick(); btn_record = 0;
    check("play_ignore_rec", 32'(record), 0);
    check("play_keep_play",  32'(play), 1);
    for (int i = 0; i < 3; i++) play_sample(i, 0, 0, ended);
    check("play3_ended", 32'(ended), 1);
    check("len_kept", 32'(length), 3);

    // Empty recording: length clears, play is then ignored.
    rec_start();
    rec_stop();
    play_start();
    repeat (3) begin
      tick();
      check("empty_play", 32'(play | read | write), 0);
    end

    // Randomized sessions with overruns and stops landing mid-access.
    for (int s = 0; s < 5; s++) begin
      n = $urandom_range(1, 8);
      rec_start();
      ended = 0;
      for (int i = 0; i < n && !ended; i++)
        rec_sample(DATA_W'($urandom), $urandom_range(0, 3) == 0,
                   (i == n - 1) && ($urandom_range(0, 1) == 1), ended);
      if (!ended) rec_stop();
      m = $urandom_range(1, ref_len);
      play_start();
      for (int i = 0; i < ref_len; i++) begin
        play_sample(i, $urandom_range(0, 3) == 0,
                    (i == m - 1) && (m < ref_len) && ($urandom_range(0, 1) == 1), ended);
        if (ended) break;
        if (i == m - 1) begin
          play_stop();
          break;
        end
      end
    end
    check("wc_random", 32'(write_cycles), 32'(exp_wc));

    // Fill the memory: auto-end on the 16th sample, no further write.
    rec_start();
    for (int i = 0; i < DEPTH; i++)
      rec_sample(DATA_W'($urandom), 0, 0, ended);
    check("full_ended", 32'(ended), 1);
    sample_valid = 1; tick(); sample_valid = 0;
    repeat (ACC + 1) tick();
    check("full_no_write", 32'(write_cycles), 32'(exp_wc));
    check("full_length",   32'(length), DEPTH);

    // Reset in the middle of a playback read.
    play_start();
    exp_q.push_back(ref_mem[0]);
    sample_valid = 1; tick(); sample_valid = 0;
    check("mid_read", 32'(read), 1);
    #2 reset_n = 0;
    #1;
    check("arst_read",   32'(read), 0);
    check("arst_play",   32'(play), 0);
    check("arst_addr",   32'(addr), 0);
    check("arst_length", 32'(length), 0);
    check("arst_record", 32'(record), 0);
    exp_q.delete();
    tick();
    reset_n = 1;
    tick();
    ref_len = 0;
    play_start();
    check("wc_final", 32'(write_cycles), 32'(exp_wc));
    check("exp_q_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
